// File: rtl/monitor_end_sim_arb_pkg.sv
// rtl/monitor_end_sim_arb_pkg.sv - shared state encoding and width helpers for the end-of-sim arbiter
package monitor_pkg;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

    // Width able to hold 0..v, never narrower than one bit.
    function automatic int cnt_width(input int v);
        return (clog2(v + 1) < 1) ? 1 : clog2(v + 1);
    endfunction

    function automatic int cid_width(input int num_ch);
        return cnt_width(num_ch);
    endfunction

    function automatic int wdog_cause_id(input int num_ch);
        return num_ch;
    endfunction

endpackage

// File: rtl/monitor_end_sim_arb_if.sv
// rtl/monitor_end_sim_arb_if.sv - request and status bundle between monitors and the end-of-sim arbiter
interface monitor_end_sim_arb_if
    import monitor_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    localparam int CID_W = cid_width(NUM_CH);

    logic [NUM_CH-1:0] ch_end_req;
    logic [NUM_CH-1:0] ch_mask;
    logic              inst_complete;
    logic              wdog_en;

    logic              monitor_end_sim;
    logic              end_pending;
    logic              first_cause_vld;
    logic [CID_W-1:0]  first_cause;
    logic [NUM_CH:0]   cause_vec;
    logic [CNT_W-1:0]  end_cycle;
    logic [CNT_W-1:0]  cycle_count;

    modport master (
        output ch_end_req, ch_mask, inst_complete, wdog_en,
        input  monitor_end_sim, end_pending, first_cause_vld, first_cause,
               cause_vec, end_cycle, cycle_count
    );

    modport slave (
        input  ch_end_req, ch_mask, inst_complete, wdog_en,
        output monitor_end_sim, end_pending, first_cause_vld, first_cause,
               cause_vec, end_cycle, cycle_count
    );

endinterface

// File: rtl/monitor_end_sim_arb_wdog.sv
// rtl/monitor_end_sim_arb_wdog.sv - no-progress watchdog counting cycles without a retired instruction
module monitor_wdog #(
    parameter int WDOG_W     = 20,
    parameter int WDOG_LIMIT = 100000
) (
    input  logic pj_clk,
    input  logic reset_l,
    input  logic inst_complete,
    input  logic wdog_en,
    input  logic run,
    output logic wdog_hit
);

    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(WDOG_LIMIT - 1);

    logic [WDOG_W-1:0] wdog_cnt;

    always_ff @(posedge pj_clk or negedge reset_l) begin
        if (!reset_l) begin
            wdog_cnt <= '0;
        end else if (inst_complete || !wdog_en || !run) begin
            wdog_cnt <= '0;
        end else if (wdog_cnt != '1) begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    // The limit-th idle cycle is the one observed with LIMIT-1 already counted.
    assign wdog_hit = run & wdog_en & ~inst_complete & (wdog_cnt == LAST);

endmodule

// File: rtl/monitor_end_sim_arb.sv
// rtl/monitor_end_sim_arb.sv - masks monitor end requests, records the first cause, drains, then ends the sim
module monitor_end_sim_arb
    import monitor_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 16,
    parameter int WDOG_W       = 20,
    parameter int WDOG_LIMIT   = 100000
) (
    input  logic                  pj_clk,
    input  logic                  reset_l,
    monitor_end_sim_arb_if.slave  bus
);

    localparam int               CID_W   = cid_width(NUM_CH);
    localparam int               DW      = cnt_width(DRAIN_CYCLES);
    localparam logic [CID_W-1:0] WDOG_ID = CID_W'(wdog_cause_id(NUM_CH));
    localparam logic [DW-1:0]    DRAIN_LD = DW'(DRAIN_CYCLES);

    logic [1:0]       state;
    logic [DW-1:0]    drain_cnt;
    logic             run;
    logic             wdog_hit;
    logic [NUM_CH:0]  eff;
    logic [NUM_CH:0]  cause_q;
    logic [CID_W-1:0] cause_sel;
    logic [CID_W-1:0] first_cause_q;
    logic             vld_q;
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] end_cyc_q;

    assign run = (state == ST_RUN);

    monitor_wdog #(
        .WDOG_W     (WDOG_W),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .pj_clk        (pj_clk),
        .reset_l       (reset_l),
        .inst_complete (bus.inst_complete),
        .wdog_en       (bus.wdog_en),
        .run           (run),
        .wdog_hit      (wdog_hit)
    );

    assign eff = {wdog_hit, bus.ch_end_req & ~bus.ch_mask};

    // Descending scan so the lowest active channel is the last assignment;
    // the watchdog id only survives when no external channel is set.
    always_comb begin
        cause_sel = WDOG_ID;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (eff[i]) cause_sel = CID_W'(i);
        end
    end

    always_ff @(posedge pj_clk or negedge reset_l) begin
        if (!reset_l) begin
            state         <= ST_RUN;
            drain_cnt     <= '0;
            cause_q       <= '0;
            first_cause_q <= '0;
            vld_q         <= 1'b0;
            cyc_q         <= '0;
            end_cyc_q     <= '0;
        end else begin
            if (cyc_q != '1) cyc_q <= cyc_q + 1'b1;

            case (state)
                ST_RUN: begin
                    if (|eff) begin
                        first_cause_q <= cause_sel;
                        vld_q         <= 1'b1;
                        end_cyc_q     <= cyc_q;
                        cause_q       <= cause_q | eff;
                        drain_cnt     <= DRAIN_LD;
                        state         <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    cause_q <= cause_q | eff;
                    if (drain_cnt == '0) begin
                        state <= ST_DONE;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign bus.monitor_end_sim = (state == ST_DONE);
    assign bus.end_pending     = (state == ST_DRAIN);
    assign bus.first_cause_vld = vld_q;
    assign bus.first_cause     = first_cause_q;
    assign bus.cause_vec       = cause_q;
    assign bus.end_cycle       = end_cyc_q;
    assign bus.cycle_count     = cyc_q;

endmodule

// File: tb/tb_monitor_end_sim_arb.sv
// tb/tb_monitor_end_sim_arb.sv - directed checks of the end-of-sim arbiter
module tb_monitor_end_sim_arb;

    logic clk;
    logic ra;
    logic rz;
    int   total;
    int   bad;

    monitor_end_sim_arb_if #(.NUM_CH(4), .CNT_W(32)) a_if ();
    monitor_end_sim_arb_if #(.NUM_CH(4), .CNT_W(4))  z_if ();

    monitor_end_sim_arb #(
        .NUM_CH(4), .CNT_W(32), .DRAIN_CYCLES(16), .WDOG_W(20), .WDOG_LIMIT(8)
    ) dut_a (
        .pj_clk  (clk),
        .reset_l (ra),
        .bus     (a_if.slave)
    );

    monitor_end_sim_arb #(
        .NUM_CH(4), .CNT_W(4), .DRAIN_CYCLES(0), .WDOG_W(8), .WDOG_LIMIT(8)
    ) dut_z (
        .pj_clk  (clk),
        .reset_l (rz),
        .bus     (z_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge a_if.monitor_end_sim)
        $display("dut_a end of sim: first_cause=%0d end_cycle=%0d", a_if.first_cause, a_if.end_cycle);
    always @(posedge z_if.monitor_end_sim)
        $display("dut_z end of sim: first_cause=%0d end_cycle=%0d", z_if.first_cause, z_if.end_cycle);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_a();
        a_if.ch_end_req    = '0;
        a_if.ch_mask       = '0;
        a_if.inst_complete = 1'b0;
        a_if.wdog_en       = 1'b0;
    endtask

    task automatic restart_a();
        ra = 1'b0;
        #1;
        ra = 1'b1;
    endtask

    initial begin
        int pend;
        int seen;
        total = 0;
        bad   = 0;
        ra    = 1'b0;
        rz    = 1'b0;
        clear_a();
        z_if.ch_end_req    = '0;
        z_if.ch_mask       = '0;
        z_if.inst_complete = 1'b0;
        z_if.wdog_en       = 1'b0;

        #1;
        chk("rst_end_sim", a_if.monitor_end_sim, 0);
        chk("rst_pending", a_if.end_pending, 0);
        chk("rst_cycle",   a_if.cycle_count, 0);

        // Idle run
        step(1);
        ra = 1'b1;
        step(50);
        chk("idle_cycle",  a_if.cycle_count, 50);
        chk("idle_vld",    a_if.first_cause_vld, 0);
        chk("idle_cvec",   a_if.cause_vec, 0);
        chk("idle_endsim", a_if.monitor_end_sim, 0);
        chk("idle_pend",   a_if.end_pending, 0);

        // Single request on channel 2 at cycle 20
        restart_a();
        step(20);
        chk("single_pre_cycle", a_if.cycle_count, 20);
        a_if.ch_end_req = 4'b0100;
        step(1);
        a_if.ch_end_req = 4'b0000;
        chk("single_pend",  a_if.end_pending, 1);
        chk("single_cause", a_if.first_cause, 2);
        chk("single_vld",   a_if.first_cause_vld, 1);
        chk("single_endcy", a_if.end_cycle, 20);
        chk("single_cvec",  a_if.cause_vec, 5'b00100);
        pend = 1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (a_if.monitor_end_sim) begin
                seen = 1;
                break;
            end
            if (a_if.end_pending) pend++;
        end
        chk("single_done_seen", seen, 1);
        chk("single_pend_len",  pend, 17);
        chk("single_done_cyc",  a_if.cycle_count, 38);
        chk("single_done_pend", a_if.end_pending, 0);
        a_if.ch_end_req = 4'b1000;
        step(3);
        a_if.ch_end_req = 4'b0000;
        chk("single_frozen_cvec", a_if.cause_vec, 5'b00100);
        chk("single_sticky",      a_if.monitor_end_sim, 1);

        // Mask plus simultaneous requests, ch3 pulse in DRAIN
        restart_a();
        step(10);
        a_if.ch_mask    = 4'b0001;
        a_if.ch_end_req = 4'b0011;
        step(1);
        a_if.ch_end_req = 4'b0000;
        chk("mask_cause", a_if.first_cause, 1);
        chk("mask_endcy", a_if.end_cycle, 10);
        chk("mask_cvec0", a_if.cause_vec, 5'b00010);
        step(3);
        a_if.ch_end_req = 4'b1001;
        step(1);
        a_if.ch_end_req = 4'b0000;
        chk("mask_cvec1",  a_if.cause_vec, 5'b01010);
        chk("mask_cause1", a_if.first_cause, 1);
        chk("mask_pend",   a_if.end_pending, 1);
        step(13);
        chk("mask_done", a_if.monitor_end_sim, 1);

        // Watchdog fires on the 8th idle cycle
        clear_a();
        a_if.wdog_en = 1'b1;
        restart_a();
        step(7);
        chk("wdog_pre_vld",  a_if.first_cause_vld, 0);
        chk("wdog_pre_pend", a_if.end_pending, 0);
        step(1);
        chk("wdog_pend",  a_if.end_pending, 1);
        chk("wdog_cause", a_if.first_cause, 4);
        chk("wdog_cvec",  a_if.cause_vec, 5'b10000);
        chk("wdog_endcy", a_if.end_cycle, 7);

        // External request coinciding with the watchdog hit
        restart_a();
        step(7);
        a_if.ch_end_req = 4'b0001;
        step(1);
        a_if.ch_end_req = 4'b0000;
        chk("sim_cause", a_if.first_cause, 0);
        chk("sim_cvec",  a_if.cause_vec, 5'b10001);

        // Regular inst_complete keeps the watchdog quiet
        restart_a();
        for (int i = 0; i < 40; i++) begin
            a_if.inst_complete = (i % 5 == 4);
            step(1);
        end
        a_if.inst_complete = 1'b0;
        chk("wdog_quiet_vld",  a_if.first_cause_vld, 0);
        chk("wdog_quiet_pend", a_if.end_pending, 0);
        clear_a();

        // Asynchronous reset in the middle of DRAIN
        restart_a();
        step(5);
        a_if.ch_end_req = 4'b0001;
        step(1);
        a_if.ch_end_req = 4'b0000;
        step(3);
        chk("mid_pend_before", a_if.end_pending, 1);
        #2;
        ra = 1'b0;
        #1;
        chk("mid_pend",  a_if.end_pending, 0);
        chk("mid_vld",   a_if.first_cause_vld, 0);
        chk("mid_cvec",  a_if.cause_vec, 0);
        chk("mid_cycle", a_if.cycle_count, 0);
        chk("mid_endcy", a_if.end_cycle, 0);
        chk("mid_cause", a_if.first_cause, 0);
        ra = 1'b1;
        step(2);
        chk("mid_run_cycle", a_if.cycle_count, 2);
        a_if.ch_end_req = 4'b1000;
        step(1);
        a_if.ch_end_req = 4'b0000;
        chk("mid_restart_pend",  a_if.end_pending, 1);
        chk("mid_restart_cause", a_if.first_cause, 3);

        // Zero drain on the second instance
        rz = 1'b1;
        step(3);
        z_if.ch_end_req = 4'b0010;
        step(1);
        z_if.ch_end_req = 4'b0000;
        chk("zero_pend",   z_if.end_pending, 1);
        chk("zero_endsim", z_if.monitor_end_sim, 0);
        chk("zero_cause",  z_if.first_cause, 1);
        chk("zero_endcy",  z_if.end_cycle, 3);
        step(1);
        chk("zero_pend2",   z_if.end_pending, 0);
        chk("zero_endsim2", z_if.monitor_end_sim, 1);

        // Four-bit cycle counter saturates
        rz = 1'b0;
        #1;
        rz = 1'b1;
        step(20);
        chk("sat_cycle", z_if.cycle_count, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/monitor_end_sim_arb.md
Name: monitor_end_sim_arb

Overview:
- Parametrised end-of-simulation arbiter for the simulation environment.
- Collects N level-sensitive end requests from the unit monitors (smu, instruction, bus, ...), applies a per-channel mask, and adds an internal no-progress watchdog as an extra cause.
- Records the first cause and the cycle at which it occurred, then holds off for a programmable drain period so the pipeline and bus can settle.
- Finally asserts a sticky monitor_end_sim toward the top-level environment.

Parameters:
- NUM_CH, 4: number of external request channels (1..15).
- CNT_W, 32: width of the free-running cycle counter and of the captured end cycle.
- DRAIN_CYCLES, 16: cycles spent in DRAIN before monitor_end_sim asserts (0 allowed).
- WDOG_W, 20: width of the watchdog counter.
- WDOG_LIMIT, 100000: consecutive cycles without inst_complete that fire the watchdog; must be at least 1 and at most 2^WDOG_W-1.

Ports:
- pj_clk  in  1  single clock.
- reset_l  in  1  asynchronous reset, active low.
- ch_end_req  in  NUM_CH  per-channel end request, level.
- ch_mask  in  NUM_CH  1 = ignore that channel entirely.
- inst_complete  in  1  instruction-retired pulse (pj_inst_complete).
- wdog_en  in  1  watchdog enable.
- monitor_end_sim  out  1  sticky end-of-simulation.
- end_pending  out  1  high while in DRAIN.
- first_cause_vld  out  1  first cause has been captured.
- first_cause  out  CID_W  index of the first cause; NUM_CH = watchdog. CID_W = clog2(NUM_CH+1).
- cause_vec  out  NUM_CH+1  sticky record of every cause seen before DONE; bit NUM_CH = watchdog.
- end_cycle  out  CNT_W  cycle_count value at first-cause capture.
- cycle_count  out  CNT_W  free-running cycle count, saturating at all-ones.

Behaviour:
- Reset: asynchronous assertion (reset_l=0) clears all state at once.
  - State goes to RUN.
  - All outputs go to 0, counters go to 0.
  - Applies from any state, including DRAIN and DONE.
- cycle_count: increments every edge, saturates at 2^CNT_W-1 and does not wrap.
- Effective request vector eff[i] = ch_end_req[i] & ~ch_mask[i] for i < NUM_CH; eff[NUM_CH] = wdog_hit.
- Watchdog counter:
  - Cleared when inst_complete=1, when wdog_en=0, or when state is not RUN.
  - Otherwise increments, saturating.
  - wdog_hit = wdog_en & ~inst_complete & (wdog_cnt == WDOG_LIMIT-1), in RUN only.
  - Result: WDOG_LIMIT consecutive cycles without inst_complete fire the watchdog.
- FSM states are RUN, DRAIN, DONE.
- RUN:
  - If |eff at edge k: latch first_cause = lowest set index (external channels beat the watchdog; lower index wins), set first_cause_vld=1, end_cycle = cycle_count value before edge k, cause_vec |= eff, load drain_cnt = DRAIN_CYCLES, go to DRAIN.
  - Otherwise stay in RUN.
- DRAIN:
  - end_pending=1.
  - cause_vec |= eff every edge; first_cause and end_cycle stay frozen.
  - If drain_cnt==0, go to DONE; else drain_cnt decrements.
- DONE:
  - monitor_end_sim=1 and end_pending=0; all capture registers frozen.
  - Stays in DONE until reset.
- Latency: a request sampled at edge k gives end_pending=1 after edge k and monitor_end_sim=1 after edge k+DRAIN_CYCLES+1. With DRAIN_CYCLES=0, monitor_end_sim asserts after edge k+1.
- Boundary rules:
  - A request that drops during DRAIN does not cancel the end.
  - ch_mask changes during DRAIN affect only cause_vec accumulation.
  - Simultaneous external request and wdog_hit: both bits are set in cause_vec; first_cause is the external index.
  - NUM_CH=1 gives CID_W=1.
- On the rising edge of monitor_end_sim, $display the first cause index and end_cycle (simulation-only block).

Decomposition:
- Shared package (monitor_pkg):
  - FSM state encoding (RUN=2'd0, DRAIN=2'd1, DONE=2'd2).
  - clog2 function and the CID_W derivation.
  - Cause-ID constant for the watchdog (= NUM_CH).
- One sub-module: monitor_wdog.
  - Watchdog counter and wdog_hit generation.
  - Parameters WDOG_W and WDOG_LIMIT.
  - Ports pj_clk, reset_l, inst_complete, wdog_en, run, wdog_hit.

Test Plan:
- Reset idle: reset_l low then high, no requests for 50 cycles -> all outputs 0, cycle_count=50, state RUN.
- Single request: DRAIN_CYCLES=16, ch_end_req=4'b0100 at cycle 20 -> first_cause=2, end_cycle=20, end_pending high for 17 cycles, monitor_end_sim=1 at cycle 38, cause_vec=5'b00100.
- Simultaneous and mask: ch_mask=4'b0001, ch_end_req=4'b0011 at cycle 10, ch3 pulses during DRAIN -> first_cause=1, cause_vec=5'b01010 (bit 0 never set).
- Watchdog: WDOG_LIMIT=8, wdog_en=1, no inst_complete after reset -> wdog_hit on the 8th cycle, first_cause=NUM_CH=4, cause_vec=5'b10000. Same setup with inst_complete every 5 cycles -> never fires.
- Zero drain: DRAIN_CYCLES=0, request sampled at edge k -> end_pending high for exactly one cycle, monitor_end_sim after edge k+1.
- Reset mid-DRAIN and saturation: assert reset_l=0 asynchronously while in DRAIN -> all outputs clear immediately and the FSM restarts in RUN. Separately, CNT_W=4 with 20 cycles of run -> cycle_count holds at 15.
